// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the modular halving helper used by the NTT datapath.
package kyber_pkg;

    localparam int   KY_Q      = 3329;
    localparam int   KY_WID    = 12;
    localparam logic MODE_NTT  = 1'b1;
    localparam logic MODE_INTT = 1'b0;

    // x/2 mod q for odd q: an odd x is made even by adding q before the shift.
    // Done in 32 bits so callers of any width up to 31 bits cannot overflow.
    function automatic logic [31:0] halfq(input logic [31:0] x, input logic [31:0] q);
        logic [31:0] y;
        y = x[0] ? (x + q) : x;
        return y >> 1;
    endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Stream interface of the butterfly: operand beat in, result beat out, plus busy.
interface butterfly_pipe_if import kyber_pkg::*; #(
    parameter int WID     = KY_WID,
    parameter int TAG_WID = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [WID-1:0]     u;
    logic [WID-1:0]     t;
    logic [WID-1:0]     w;
    logic [TAG_WID-1:0] in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WID-1:0]     s0;
    logic [WID-1:0]     s1;
    logic [TAG_WID-1:0] out_tag;
    logic               busy;

    modport master (
        output in_valid, mode, u, t, w, in_tag, out_ready,
        input  in_ready, out_valid, s0, s1, out_tag, busy
    );

    modport slave (
        input  in_valid, mode, u, t, w, in_tag, out_ready,
        output in_ready, out_valid, s0, s1, out_tag, busy
    );
endinterface

// File: rtl/mod_barrett_red.sv
// Registered Barrett reduction of a 2*WID-bit product (< Q^2) to a residue < Q.
module mod_barrett_red import kyber_pkg::*; #(
    parameter int WID = KY_WID,
    parameter int Q   = KY_Q
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2*WID-1:0]   x,
    output logic [WID-1:0]     r
);
    localparam int              PW = 4*WID + 2;
    localparam logic [PW-1:0]   K  = PW'((64'd1 << (2*WID)) / 64'(Q));
    localparam logic [2*WID-1:0] QX = (2*WID)'(Q);
    localparam logic [WID+1:0]  QR = (WID+2)'(Q);

    logic [PW-1:0]  xk;
    logic [WID-1:0] qe;
    logic [WID+1:0] r0, r1, r2;

    // Quotient estimate undershoots by at most 2, so the remainder is < 3Q.
    always_comb begin
        xk = PW'(x) * K;
        qe = WID'(xk >> (2*WID));
        r0 = (WID+2)'(x - (2*WID)'(qe) * QX);
        r1 = (r0 >= QR) ? (r0 - QR) : r0;
        r2 = (r1 >= QR) ? (r1 - QR) : r1;
    end

    // Single output register, advanced together with the surrounding pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r <= '0;
        else if (en)
            r <= WID'(r2);
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Mixed-mode Kyber butterfly: CT for NTT, GS with folded 1/2 for INTT, equal latency.
module butterfly_pipe import kyber_pkg::*; #(
    parameter int WID        = KY_WID,
    parameter int Q          = KY_Q,
    parameter int MUL_STAGES = 2,
    parameter int TAG_WID    = 8
) (
    input  logic           clk,
    input  logic           rst,
    butterfly_pipe_if.slave bus
);
    localparam int PW = 2*WID;

    logic               adv;
    logic               v1, m1;
    logic [WID-1:0]     u1, t1, w1;
    logic [TAG_WID-1:0] g1;
    logic [WID-1:0]     a1, d1, b1;

    logic               mv [MUL_STAGES];
    logic               mm [MUL_STAGES];
    logic [WID-1:0]     mx [MUL_STAGES];
    logic [TAG_WID-1:0] mg [MUL_STAGES];
    logic [PW-1:0]      mp [MUL_STAGES];
    logic               any_mv;

    logic               rv, rm;
    logic [WID-1:0]     rx, rp;
    logic [TAG_WID-1:0] rg;
    logic [WID-1:0]     f0, f1;

    function automatic logic [WID-1:0] addq(input logic [WID-1:0] a, input logic [WID-1:0] b);
        logic [WID:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (WID+1)'(Q))
            s = s - (WID+1)'(Q);
        return WID'(s);
    endfunction

    function automatic logic [WID-1:0] subq(input logic [WID-1:0] a, input logic [WID-1:0] b);
        logic [WID:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (s[WID])
            s = s + (WID+1)'(Q);
        return WID'(s);
    endfunction

    assign adv          = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    // Stage-1 pre-add/sub for GS and per-beat multiplier operand select.
    always_comb begin
        a1 = addq(u1, t1);
        d1 = subq(u1, t1);
        b1 = (m1 == MODE_NTT) ? t1 : d1;
    end

    // Valid bits: the only pipeline state that must be cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++)
                mv[i] <= 1'b0;
            rv <= 1'b0;
        end else if (adv) begin
            v1    <= bus.in_valid;
            mv[0] <= v1;
            for (int i = 1; i < MUL_STAGES; i++)
                mv[i] <= mv[i-1];
            rv <= mv[MUL_STAGES-1];
        end
    end

    // Data path: operands, product shift register and aligned sideband (u or a, mode, tag).
    always_ff @(posedge clk) begin
        if (adv) begin
            m1    <= bus.mode;
            u1    <= bus.u;
            t1    <= bus.t;
            w1    <= bus.w;
            g1    <= bus.in_tag;
            mm[0] <= m1;
            mx[0] <= (m1 == MODE_NTT) ? u1 : a1;
            mg[0] <= g1;
            mp[0] <= PW'(w1) * PW'(b1);
            for (int i = 1; i < MUL_STAGES; i++) begin
                mm[i] <= mm[i-1];
                mx[i] <= mx[i-1];
                mg[i] <= mg[i-1];
                mp[i] <= mp[i-1];
            end
            rm <= mm[MUL_STAGES-1];
            rx <= mx[MUL_STAGES-1];
            rg <= mg[MUL_STAGES-1];
        end
    end

    mod_barrett_red #(.WID(WID), .Q(Q)) u_red (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .x   (mp[MUL_STAGES-1]),
        .r   (rp)
    );

    // Final stage: CT add/sub of the reduced product, or GS halving of both legs.
    always_comb begin
        f0 = '0;
        f1 = '0;
        if (rm == MODE_NTT) begin
            f0 = addq(rx, rp);
            f1 = subq(rx, rp);
        end else begin
            f0 = WID'(halfq(32'(rx), 32'(Q)));
            f1 = WID'(halfq(32'(rp), 32'(Q)));
        end
    end

    // Output register; holds its contents while the downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.s0        <= '0;
            bus.s1        <= '0;
            bus.out_tag   <= '0;
        end else if (adv) begin
            bus.out_valid <= rv;
            bus.s0        <= f0;
            bus.s1        <= f1;
            bus.out_tag   <= rg;
        end
    end

    // Reduce the multiplier-stage valid bits for busy.
    always_comb begin
        any_mv = 1'b0;
        for (int i = 0; i < MUL_STAGES; i++)
            any_mv = any_mv | mv[i];
    end

    assign bus.busy = v1 | any_mv | rv | bus.out_valid;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: driver pushes model results, monitor pops on transfer.
module tb_butterfly_pipe;
    import kyber_pkg::*;

    localparam int WID = 12;
    localparam int Q   = 3329;
    localparam int MS  = 2;
    localparam int TW  = 8;
    localparam int LAT = MS + 3;

    typedef struct {
        int s0;
        int s1;
        int tag;
        int cyc;
        bit chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   tag_n = 0;
    bit   lat_ok = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    butterfly_pipe_if #(.WID(WID), .TAG_WID(TW)) bus ();

    butterfly_pipe #(.WID(WID), .Q(Q), .MUL_STAGES(MS), .TAG_WID(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain modular arithmetic; division by 2 is multiplication by 2^-1 mod Q.
    task automatic model(input bit m, input int u, input int t, input int w,
                         output int r0, output int r1);
        int inv2, p, a, d;
        inv2 = (Q + 1) / 2;
        if (m) begin
            p  = (w * t) % Q;
            r0 = (u + p) % Q;
            r1 = (u - p + Q) % Q;
        end else begin
            a  = (u + t) % Q;
            d  = (u - t + Q) % Q;
            r0 = (a * inv2) % Q;
            r1 = (((w * d) % Q) * inv2) % Q;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic send(input bit m, input int u, input int t, input int w,
                        input bit dir, input int e0, input int e1);
        exp_t e;
        int   r0, r1, n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.u        = WID'(u);
        bus.t        = WID'(t);
        bus.w        = WID'(w);
        bus.in_tag   = TW'(tag_n);
        if (dir) begin
            r0 = e0;
            r1 = e1;
        end else begin
            model(m, u, t, w, r0, r1);
        end
        e.s0  = r0;
        e.s1  = r1;
        e.tag = tag_n;
        e.chk = lat_ok;
        n = 0;
        forever begin
            #1;
            if (bus.in_ready) begin
                e.cyc = cyc;
                sbq.push_back(e);
                acc_cnt++;
                tag_n = (tag_n + 1) % 256;
                @(posedge clk);
                break;
            end
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout got in_ready=0 exp=1");
                bus.in_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({name, "_left"}, sbq.size(), 0);
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got tag=%0d exp=none", bus.out_tag);
                end else begin
                    e = sbq.pop_front();
                    check("s0", int'(bus.s0), e.s0);
                    check("s1", int'(bus.s1), e.s1);
                    check("tag", int'(bus.out_tag), e.tag);
                    if (e.chk)
                        check("latency", cyc - e.cyc, LAT);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1+2*WID+TW-1:0] snap;
        int n;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.u         = '0;
        bus.t         = '0;
        bus.w         = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_s0", int'(bus.s0), 0);
        check("rst_s1", int'(bus.s1), 0);
        check("rst_tag", int'(bus.out_tag), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);

        // directed values
        send(MODE_NTT, 100, 2, 3, 1'b1, 106, 94);
        idle();
        drain("ntt_basic");
        send(MODE_NTT, 3328, 1, 1, 1'b1, 0, 3327);
        send(MODE_NTT, 0, 5, 1, 1'b1, 5, 3324);
        send(MODE_INTT, 10, 4, 5, 1'b1, 7, 15);
        send(MODE_INTT, 1, 0, 1, 1'b1, 1665, 1665);
        idle();
        drain("directed");

        // interleaved random stream, back to back
        for (int i = 0; i < 64; i++)
            send(bit'(i % 2), int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)),
                 int'($urandom_range(0, Q-1)), 1'b0, 0, 0);
        idle();
        drain("interleave");

        // backpressure with a full pipe
        lat_ok  = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(bit'($urandom_range(0, 1)), int'($urandom_range(0, Q-1)),
                         int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), 1'b0, 0, 0);
                idle();
            end
            begin
                n = 0;
                while (acc_cnt < 6 && n < 100) begin
                    @(negedge clk);
                    #3;
                    n++;
                end
                check("bp_fill", int'(acc_cnt >= 6), 1);
                @(negedge clk);
                bus.out_ready = 1'b0;
                #2;
                snap = {bus.out_valid, bus.s0, bus.s1, bus.out_tag};
                check("bp_full", int'(bus.out_valid), 1);
                for (int i = 0; i < 7; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        #2;
                    end
                    check("bp_in_ready", int'(bus.in_ready), 0);
                    check("bp_hold", int'({bus.out_valid, bus.s0, bus.s1, bus.out_tag} == snap), 1);
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_busy_last", int'(bus.busy), 1);
        @(negedge clk);
        #3;
        check("bp_busy_fall", int'(bus.busy), 0);

        // reset mid-stream with three beats in flight
        lat_ok = 1'b1;
        for (int i = 0; i < 3; i++)
            send(bit'(i % 2), int'($urandom_range(1, Q-1)), int'($urandom_range(0, Q-1)),
                 int'($urandom_range(1, Q-1)), 1'b0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_s0", int'(bus.s0), 0);
        check("mid_rst_s1", int'(bus.s1), 0);
        bus.in_valid = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        repeat (15) @(negedge clk);
        #3;
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_out_valid", int'(bus.out_valid), 0);

        check("final_queue", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Fully pipelined, parametrised Kyber butterfly with a valid/ready stream interface. It executes Cooley-Tukey (NTT) or Gentleman-Sande (INTT, with the ×1/2 folded in) on every accepted beat. Mode travels with each beat, so NTT and INTT operations may be interleaved cycle by cycle, and both modes have the same fixed latency. It sits between the coefficient-RAM read ports and write-back in the NTT/INTT datapath, and replaces the fixed-mode, unequal-latency butterfly.

## Interface
Parameters:
- WID, 12, coefficient width; requires Q < 2^WID.
- Q, 3329, odd modulus.
- MUL_STAGES, 2, pipeline registers inside the WID×WID multiplier; ≥1.
- TAG_WID, 8, sideband tag width (write-back address), carried unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- mode  in  1  1 = NTT (CT), 0 = INTT (GS); sampled with the beat.
- u, t, w  in  WID each  operands; must be < Q, otherwise output is undefined.
- in_tag  in  TAG_WID  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- s0, s1  out  WID each  results, always < Q.
- out_tag  out  TAG_WID  tag of the result beat.
- busy  out  1  any pipeline stage holds a valid beat.

## Operation
- NTT: p = w·t mod Q; s0 = (u + p) mod Q; s1 = (u − p) mod Q.
- INTT: a = (u + t) mod Q; d = (u − t) mod Q; s0 = a/2 mod Q; s1 = (w·d mod Q)/2 mod Q.
- Halving mod Q: x even → x>>1; x odd → (x+Q)>>1. Compute the intermediate in WID+1 bits.
- Modular add: add in WID+1 bits, then subtract Q if the result is ≥ Q. Modular sub: compute u−v; add Q if it borrowed.
- Multiplier operand b is t in NTT mode and d in INTT mode; the selection is per beat, driven by the stage-1 mode bit.
- Reduction is Barrett: K = floor(2^(2·WID)/Q) as a localparam. Apply at most two conditional subtractions; the output must be < Q for every product < Q².
- Pipeline stages:
  - S1: register u, t, w, mode, tag.
  - M1..M(MUL_STAGES): product.
  - R: reduced product.
  - F: add/sub (NTT) or halve (INTT), registered to the outputs.
- u (NTT) and a (INTT) are delayed alongside the product to reach F aligned. Each stage carries its own valid bit and its own mode bit.

## Timing
- Latency LAT = MUL_STAGES + 3 cycles, from the accept edge to the cycle with out_valid high. This is identical for both modes.
- Global stall: adv = !out_valid | out_ready. in_ready = adv.
  - When adv = 0, every stage holds, and s0/s1/out_tag stay stable.
  - When adv = 1, every stage shifts and an empty slot is filled with valid = 0.
- Bubbles are not squeezed out.
- Throughput is one beat per cycle while out_ready is held high.
- A beat is accepted iff in_valid && in_ready. in_valid while in_ready is low is ignored; the source must hold the beat.
- A result transfers iff out_valid && out_ready.
- busy = OR of all stage valid bits.
- Reset (rst = 0, async) clears:
  - all valid bits, so out_valid = 0 and busy = 0;
  - s0, s1, out_tag, which go to 0.
  - in_ready = 1 as soon as reset releases.
- A reset during operation discards every in-flight beat; nothing is emitted afterwards for those beats.
- Data registers other than the outputs need no reset.

## Structure
- kyber_pkg holds:
  - KY_Q = 3329, KY_WID = 12;
  - MODE_NTT = 1'b1, MODE_INTT = 1'b0;
  - function halfq(x, q).
- One sub-module: mod_barrett_red (parameters WID, Q; a 2·WID-bit product in, WID out; one register stage, active-low asynchronous rst). It is reusable by the pointwise-multiply unit.
- The multiplier is an inline shift register of MUL_STAGES product registers. The synthesis tool retimes it into the DSP.

## Test plan
- NTT basic: u=100, t=2, w=3 → s0=106, s1=94, exactly LAT cycles after accept.
- NTT wrap: u=3328, t=1, w=1 → s0=0, s1=3327. Also u=0, t=5, w=1 → s0=5, s1=3324.
- INTT halving: u=10, t=4, w=5 → s0=7, s1=15. u=1, t=0, w=1 → s0=1665, s1=1665.
- Interleaved modes:
  - Stimulus: 64 back-to-back beats, alternating mode, random operands < Q, out_ready held high.
  - Required: one result per cycle, in order, tags matching, all values equal to the reference model.
- Backpressure:
  - Stimulus: drive out_ready low for 7 cycles with a full pipe.
  - Required: in_ready = 0 and outputs stable for that whole window. After release there are no drops or duplicates, and busy falls one cycle after the last result transfers.
- Reset mid-stream: assert rst low asynchronously (between edges) with 3 beats in flight → out_valid, busy, s0, s1 go to 0 immediately. No stale results appear after rst returns high.
